// File: rtl/loop_sequencer_if.sv
// Handshake/data bundle between a loop_sequencer and whoever launches it.
interface loop_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] step;
    logic             down;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] iters;
    logic             busy;
    logic             iter_tick;
    logic             done;
    logic             wrap;

    modport master (
        output start, abort, init, limit, step, down,
        input  count, iters, busy, iter_tick, done, wrap
    );

    modport slave (
        input  start, abort, init, limit, step, down,
        output count, iters, busy, iter_tick, done, wrap
    );
endinterface

// File: rtl/loop_sequencer.sv
// Bounded while-loop in hardware: steps a value up or down every PRESCALE
// clocks while it stays on the right side of a latched limit.
module loop_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input logic           clk,
    input logic           rstn,
    loop_sequencer_if.slave bus
);
    localparam int             PW       = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [0:0]     S_IDLE   = 1'b0;
    localparam logic [0:0]     S_RUN    = 1'b1;

    logic [0:0]       r_state;
    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_step;
    logic             r_down;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_iters;
    logic             r_tick;
    logic             r_done;
    logic             r_wrap;

    logic [WIDTH:0]   w_next;
    logic             w_carry;
    logic             w_init_ok;
    logic             w_next_ok;

    function automatic logic f_holds(input logic [WIDTH-1:0] v,
                                     input logic [WIDTH-1:0] lim,
                                     input logic             dn);
        return dn ? (v >= lim) : (v <= lim);
    endfunction

    // The extra top bit is the carry (up) or borrow (down) that signals wrap.
    // NOTE: always_comb assigns every output unconditionally, so no latch is inferred.
    always_comb begin
        w_next    = r_down ? ({1'b0, r_count} - {1'b0, r_step})
                           : ({1'b0, r_count} + {1'b0, r_step});
        w_carry   = w_next[WIDTH];
        w_init_ok = f_holds(bus.init, bus.limit, bus.down);
        w_next_ok = f_holds(w_next[WIDTH-1:0], r_limit, r_down);
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_limit <= '0;
            r_step  <= '0;
            r_down  <= 1'b0;
            r_count <= '0;
            r_iters <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_limit <= bus.limit;
                        r_step  <= bus.step;
                        r_down  <= bus.down;
                        r_count <= bus.init;
                        r_iters <= '0;
                        r_wrap  <= 1'b0;
                        r_pre   <= '0;
                        if (w_init_ok) r_state <= S_RUN;
                        else           r_done  <= 1'b1;
                    end
                end
                default: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (r_pre == PRE_LAST) begin
                        r_pre <= '0;
                        if (w_carry) begin
                            r_wrap  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_count <= w_next[WIDTH-1:0];
                            r_tick  <= 1'b1;
                            if (r_iters != '1) r_iters <= r_iters + WIDTH'(1);
                            if (!w_next_ok) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end else begin
                        r_pre <= r_pre + PW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.count     = r_count;
    assign bus.iters     = r_iters;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.iter_tick = r_tick;
    assign bus.done      = r_done;
    assign bus.wrap      = r_wrap;
endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench for loop_sequencer: three configurations, expected
// update/done events queued at launch and matched by per-instance monitors.
module tb_loop_sequencer;
    logic clk;
    logic rstn;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   c0;

    typedef struct {
        int         at;
        logic [7:0] count;
        logic [7:0] iters;
        logic       tick;
        logic       done;
        logic       wrap;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    loop_sequencer_if #(.WIDTH(4)) if0 ();
    loop_sequencer_if #(.WIDTH(4)) if1 ();
    loop_sequencer_if #(.WIDTH(8)) if2 ();

    loop_sequencer #(.WIDTH(4), .PRESCALE(10)) u0 (.clk(clk), .rstn(rstn), .bus(if0));
    loop_sequencer #(.WIDTH(4), .PRESCALE(1))  u1 (.clk(clk), .rstn(rstn), .bus(if1));
    loop_sequencer #(.WIDTH(8), .PRESCALE(3))  u2 (.clk(clk), .rstn(rstn), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int d, input int at, input int c, input int it,
                        input logic tk, input logic dn, input logic wr);
        exp_t e;
        e.at = at; e.count = 8'(c); e.iters = 8'(it);
        e.tick = tk; e.done = dn; e.wrap = wr;
        case (d)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic mon(input int d, input logic tk, input logic dn, input logic wr,
                       input logic [7:0] c, input logic [7:0] it);
        exp_t e;
        int   n;
        n = (d == 0) ? sb0.size() : (d == 1) ? sb1.size() : sb2.size();
        if (n == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb%0d unexpected event cyc=%0d count=%0d iters=%0d tick=%0b done=%0b wrap=%0b",
                     d, cyc, c, it, tk, dn, wr);
        end else begin
            case (d)
                0:       e = sb0.pop_front();
                1:       e = sb1.pop_front();
                default: e = sb2.pop_front();
            endcase
            check($sformatf("sb%0d cycle", d), cyc, e.at);
            check($sformatf("sb%0d count", d), 32'(c), 32'(e.count));
            check($sformatf("sb%0d iters", d), 32'(it), 32'(e.iters));
            check($sformatf("sb%0d tick", d), 32'(tk), 32'(e.tick));
            check($sformatf("sb%0d done", d), 32'(dn), 32'(e.done));
            check($sformatf("sb%0d wrap", d), 32'(wr), 32'(e.wrap));
        end
    endtask

    always @(negedge clk)
        if (rstn && (if0.iter_tick || if0.done))
            mon(0, if0.iter_tick, if0.done, if0.wrap, 8'(if0.count), 8'(if0.iters));
    always @(negedge clk)
        if (rstn && (if1.iter_tick || if1.done))
            mon(1, if1.iter_tick, if1.done, if1.wrap, 8'(if1.count), 8'(if1.iters));
    always @(negedge clk)
        if (rstn && (if2.iter_tick || if2.done))
            mon(2, if2.iter_tick, if2.done, if2.wrap, if2.count, if2.iters);

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        {if0.start, if0.abort, if0.init, if0.limit, if0.step, if0.down} = '0;
        {if1.start, if1.abort, if1.init, if1.limit, if1.step, if1.down} = '0;
        {if2.start, if2.abort, if2.init, if2.limit, if2.step, if2.down} = '0;
        rstn = 1'b0;
        #1;
        check("rst count",  32'(if0.count), 0);
        check("rst iters",  32'(if0.iters), 0);
        check("rst busy",   32'(if0.busy), 0);
        check("rst tick",   32'(if0.iter_tick), 0);
        check("rst done",   32'(if0.done), 0);
        check("rst wrap",   32'(if0.wrap), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Up sweep 0..11 at PRESCALE=10, with mid-run start and input changes.
        c0 = cyc;
        if0.init = 4'd0; if0.limit = 4'd10; if0.step = 4'd1; if0.down = 1'b0; if0.start = 1'b1;
        for (int k = 1; k <= 11; k++) push(0, c0 + 1 + 10 * k, k, k, 1'b1, k == 11, 1'b0);
        @(negedge clk);
        if0.start = 1'b0;
        check("s1 launch busy",  32'(if0.busy), 1);
        check("s1 launch count", 32'(if0.count), 0);
        wait_until(c0 + 50);
        if0.start = 1'b1; if0.init = 4'd7; if0.limit = 4'd3; if0.step = 4'd2; if0.down = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        check("s1 midrun busy",  32'(if0.busy), 1);
        check("s1 midrun count", 32'(if0.count), 5);
        wait_until(c0 + 111);
        check("s1 end busy",  32'(if0.busy), 0);
        check("s1 end count", 32'(if0.count), 11);
        check("s1 end iters", 32'(if0.iters), 11);
        check("s1 end wrap",  32'(if0.wrap), 0);
        if0.init = 4'd0; if0.limit = 4'd10; if0.step = 4'd1; if0.down = 1'b0;
        wait_until(c0 + 115);

        // Abort at cycle 25 of the same sweep.
        c0 = cyc;
        if0.start = 1'b1;
        push(0, c0 + 11, 1, 1, 1'b1, 1'b0, 1'b0);
        push(0, c0 + 21, 2, 2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        if0.start = 1'b0;
        wait_until(c0 + 25);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        check("abort busy",  32'(if0.busy), 0);
        check("abort count", 32'(if0.count), 2);
        check("abort iters", 32'(if0.iters), 2);
        check("abort done",  32'(if0.done), 0);
        wait_until(c0 + 60);
        check("abort hold count", 32'(if0.count), 2);

        // start together with abort in IDLE must not launch.
        if0.start = 1'b1; if0.abort = 1'b1;
        @(negedge clk);
        if0.start = 1'b0; if0.abort = 1'b0;
        check("st+ab busy",  32'(if0.busy), 0);
        check("st+ab count", 32'(if0.count), 2);
        repeat (12) @(negedge clk);
        check("st+ab later busy", 32'(if0.busy), 0);

        // Carry wrap, up mode.
        c0 = cyc;
        if1.init = 4'd14; if1.limit = 4'd15; if1.step = 4'd1; if1.down = 1'b0; if1.start = 1'b1;
        push(1, c0 + 2, 15, 1, 1'b1, 1'b0, 1'b0);
        push(1, c0 + 3, 15, 1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        if1.start = 1'b0;
        wait_until(c0 + 3);
        check("wrap up busy", 32'(if1.busy), 0);
        wait_until(c0 + 6);
        check("wrap up held", 32'(if1.wrap), 1);
        check("wrap up count", 32'(if1.count), 15);

        // Borrow wrap, down mode.
        c0 = cyc;
        if1.init = 4'd1; if1.limit = 4'd0; if1.step = 4'd1; if1.down = 1'b1; if1.start = 1'b1;
        push(1, c0 + 2, 0, 1, 1'b1, 1'b0, 1'b0);
        push(1, c0 + 3, 0, 1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        if1.start = 1'b0;
        wait_until(c0 + 3);
        check("wrap dn wrap", 32'(if1.wrap), 1);
        check("wrap dn busy", 32'(if1.busy), 0);

        // Zero-iteration launches.
        c0 = cyc;
        if1.init = 4'd12; if1.limit = 4'd10; if1.step = 4'd1; if1.down = 1'b0; if1.start = 1'b1;
        push(1, c0 + 1, 12, 0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("zero up busy",  32'(if1.busy), 0);
        check("zero up iters", 32'(if1.iters), 0);
        check("zero up wrap",  32'(if1.wrap), 0);
        c0 = cyc;
        if1.init = 4'd3; if1.limit = 4'd5; if1.down = 1'b1;
        push(1, c0 + 1, 3, 0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        if1.start = 1'b0;
        check("zero dn busy", 32'(if1.busy), 0);
        repeat (3) @(negedge clk);
        check("zero dn later busy", 32'(if1.busy), 0);

        // Down sweep 20 -> 4 by 4 at PRESCALE=3.
        c0 = cyc;
        if2.init = 8'd20; if2.limit = 8'd5; if2.step = 8'd4; if2.down = 1'b1; if2.start = 1'b1;
        push(2, c0 + 4,  16, 1, 1'b1, 1'b0, 1'b0);
        push(2, c0 + 7,  12, 2, 1'b1, 1'b0, 1'b0);
        push(2, c0 + 10,  8, 3, 1'b1, 1'b0, 1'b0);
        push(2, c0 + 13,  4, 4, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        if2.start = 1'b0;
        check("dn launch count", 32'(if2.count), 20);
        wait_until(c0 + 13);
        check("dn end busy",  32'(if2.busy), 0);
        check("dn end iters", 32'(if2.iters), 4);
        wait_until(c0 + 15);

        // Asynchronous reset between edges in the middle of a run.
        c0 = cyc;
        if2.start = 1'b1;
        push(2, c0 + 4, 16, 1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        if2.start = 1'b0;
        wait_until(c0 + 5);
        #2 rstn = 1'b0;
        #1;
        check("arst count", 32'(if2.count), 0);
        check("arst iters", 32'(if2.iters), 0);
        check("arst busy",  32'(if2.busy), 0);
        check("arst u0 count", 32'(if0.count), 0);
        check("arst u1 count", 32'(if1.count), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Fresh run after reset: 9 -> 6 -> 3 -> 0 (0 < 3 ends it).
        c0 = cyc;
        if2.init = 8'd9; if2.limit = 8'd3; if2.step = 8'd3; if2.down = 1'b1; if2.start = 1'b1;
        push(2, c0 + 4,  6, 1, 1'b1, 1'b0, 1'b0);
        push(2, c0 + 7,  3, 2, 1'b1, 1'b0, 1'b0);
        push(2, c0 + 10, 0, 3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        if2.start = 1'b0;
        check("post rst count", 32'(if2.count), 9);
        check("post rst busy",  32'(if2.busy), 1);
        wait_until(c0 + 12);
        check("post rst end count", 32'(if2.count), 0);
        check("post rst end busy",  32'(if2.busy), 0);

        repeat (5) @(negedge clk);
        check("sb0 drained", 32'(sb0.size()), 0);
        check("sb1 drained", 32'(sb1.size()), 0);
        check("sb2 drained", 32'(sb2.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
